complex_mag_stream_mul_pipe: RTL
================================

# complex_mag_stream_mul_pipe

Parametrised, ce-stallable pipelined multiplier for the complex_mag_stream datapath. It is the successor to the fixed single-register multiplier instances. It adds a configurable pipeline depth, run-time per-operand signedness, a post-multiply arithmetic right shift, signed saturation to the output width with a sticky-free per-sample flag, and a valid bit carried alongside the data. It sits between the squaring/accumulate stages of the magnitude pipeline and the downstream stream formatter.

## Interface
- ID, 1, instance tag; no functional effect
- NUM_STAGE, 2, register stages from input to output; legal range 1..4
- din0_WIDTH, 16, operand 0 width
- din1_WIDTH, 16, operand 1 width
- dout_WIDTH, 32, output width; two's complement
- SHIFT, 0, arithmetic right shift applied to the full product; legal range 0..(din0_WIDTH+din1_WIDTH)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset; synchronous and active-high
- ce  in  1  clock enable; when low, every stage holds
- in_valid  in  1  din0/din1/mode qualify a sample
- din0  in  din0_WIDTH  operand 0
- din1  in  din1_WIDTH  operand 1
- din0_signed  in  1  1 = din0 is two's complement, 0 = unsigned
- din1_signed  in  1  1 = din1 is two's complement, 0 = unsigned
- out_valid  out  1  dout/sat qualify a result
- dout  out  dout_WIDTH  shifted, saturated product
- sat  out  1  this result was clipped

## Operation
- Extension: each operand is extended by 1 bit. The extension is a sign extension when its signed flag is 1 and a zero extension otherwise.
- Product: the extended operands are multiplied as signed values at full width P = din0_WIDTH+din1_WIDTH+2. The product is exact, with no overflow possible.
- Shift: the product is arithmetically right-shifted by SHIFT. Truncation is toward minus infinity (floor). No rounding.
- Saturation: if the shifted value is greater than 2^(dout_WIDTH-1)-1, dout is 2^(dout_WIDTH-1)-1 and sat=1. If it is less than -2^(dout_WIDTH-1), dout is -2^(dout_WIDTH-1) and sat=1. Otherwise dout is the low dout_WIDTH bits and sat=0.
- Pipeline: extend, multiply, shift and saturate are combinational into stage 1. Stages 2..NUM_STAGE are pure delay of {valid, sat, data}.
- The valid bit travels with its data. out_valid=0 samples still propagate data, but downstream ignores them.
- A sample with in_valid=0 enters as a bubble: valid=0 and data don't-care. All data registers still load.

## Timing
- Reset: on a rising edge with reset=1, every stage clears valid, sat and data to 0, regardless of ce. Outputs are out_valid=0, sat=0, dout=0 on the following cycle. Reset wins over ce.
- Latency: exactly NUM_STAGE rising edges with ce=1 from sample capture to out_valid/dout/sat.
- ce=0: all stages hold; outputs are stable; inputs presented in that cycle are not captured.
- Throughput: one sample per ce=1 cycle. There is no backpressure port; the upstream stage gates with ce.
- Reset mid-operation flushes all in-flight samples. The first post-reset out_valid comes NUM_STAGE ce-cycles after the first post-reset in_valid.
- Mode flags are sampled with their operands. Changing the flags cycle-to-cycle is legal and affects only that sample.
- Boundary: the most negative times the most negative signed input (e.g. -32768 × -32768) is exact in P bits, then saturates per the output range.

## Structure
- Package complex_mag_stream_mul_pkg holds:
  - the product-width calculation P
  - the saturation max/min constant functions of dout_WIDTH
  - the NUM_STAGE/SHIFT legal-range checks as elaboration-time assertions
- Sub-module complex_mag_stream_pipe_reg: parametrised width/depth delay line with ce gating and synchronous active-high clear. It is instantiated once for the {valid, sat, data} bundle with depth NUM_STAGE-1.

## Test plan
- Defaults, unsigned × unsigned: 0xFFFF × 0xFFFF, in_valid=1 -> after 2 ce cycles, dout=0x7FFFFFFF, sat=1, out_valid=1.
- Signed × signed: -1 × -1 -> dout=1, sat=0. Signed -32768 × unsigned 2 -> dout=0xFFFF0000, sat=0.
- Mixed: din0 signed 0xFFFF (-1) × din1 unsigned 0xFFFF -> dout=0xFFFF0001 (-65535), sat=0.
- SHIFT=4 instance: -17 × 1 (both signed) -> dout=-2. 100 × 3 -> dout=18.
- ce stall, NUM_STAGE=3: issue A=3×5 and B=7×2 back-to-back, hold ce=0 for 4 cycles mid-flight -> outputs frozen during the stall; 15 then 14 emerge after 3 total ce cycles each, with no duplicate or lost out_valid.
- Reset with 2 samples in flight -> next cycle out_valid=0, dout=0, sat=0. Pipeline stays empty until new in_valid; reset takes effect even with ce=0.

Source files
------------

// File: rtl/complex_mag_stream_mul_pkg.sv
// complex_mag_stream_mul_pkg
//   Shared definitions for the complex_mag_stream multiplier pipeline:
//   full-product width, saturation bounds as functions of the output
//   width, and legality checks used when the multiplier is elaborated.
//   No ports (package).
package complex_mag_stream_mul_pkg;

  // Saturation math is done in a fixed wide signed container so the
  // bounds can be expressed independently of any one instance's widths.
  localparam int unsigned WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Each operand gains one extension bit, so the product of two
  // (w+1)-bit signed values is exact in w0+w1+2 bits.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic wide_t sat_max(input int dw);
    return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int dw);
    return -(wide_t'(1) <<< (dw - 1));
  endfunction

  function automatic bit num_stage_ok(input int n);
    return (n >= 1) && (n <= 4);
  endfunction

  function automatic bit shift_ok(input int s, input int w0, input int w1);
    return (s >= 0) && (s <= w0 + w1);
  endfunction

  function automatic bit width_ok(input int p, input int dw);
    return (p <= int'(WIDE_W)) && (dw >= 2) && (dw < int'(WIDE_W));
  endfunction

endpackage

// File: rtl/complex_mag_stream_pipe_reg.sv
// complex_mag_stream_pipe_reg
//   Clock-enabled delay line of DEPTH registers, WIDTH bits each, with a
//   synchronous active-high clear that overrides ce. DEPTH=0 is a wire.
// Ports:
//   clk   in  clock
//   reset in  synchronous clear, active high
//   ce    in  clock enable; all stages hold when low
//   din   in  WIDTH  data into the first stage
//   dout  out WIDTH  data out of the last stage
module complex_mag_stream_pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
    // Clock controls have nothing to drive in a zero-depth line.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, reset, ce};
  end else begin : g_line
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] stage_in [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_in[gi] = din;
      end else begin : g_next
        assign stage_in[gi] = stage_q[gi-1];
      end

      always_comb begin
        stage_d[gi] = stage_q[gi];
        if (ce) begin
          stage_d[gi] = stage_in[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          stage_q[gi] <= '0;
        end else begin
          stage_q[gi] <= stage_d[gi];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/complex_mag_stream_mul_pipe.sv
// complex_mag_stream_mul_pipe
//   Pipelined multiplier with per-sample operand signedness, arithmetic
//   right shift of the exact product, signed saturation to dout_WIDTH and
//   a valid bit carried with the data. Extend/multiply/shift/saturate feed
//   stage 1; stages 2..NUM_STAGE are a plain delay of {valid, sat, data}.
// Ports:
//   clk, reset (sync, active high), ce (stall when low)
//   in_valid, din0, din1, din0_signed, din1_signed  : input sample
//   out_valid, dout, sat                              : result
module complex_mag_stream_mul_pipe
  import complex_mag_stream_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 32,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  output logic                  out_valid,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat
);

  localparam int    P     = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int    BW    = dout_WIDTH + 2;
  localparam wide_t MAX_V = sat_max(dout_WIDTH);
  localparam wide_t MIN_V = sat_min(dout_WIDTH);

  if (!num_stage_ok(NUM_STAGE)) begin : g_bad_stage
    $error("complex_mag_stream_mul_pipe: NUM_STAGE must be 1..4");
  end
  if (!shift_ok(SHIFT, din0_WIDTH, din1_WIDTH)) begin : g_bad_shift
    $error("complex_mag_stream_mul_pipe: SHIFT out of range");
  end
  if (!width_ok(P, dout_WIDTH)) begin : g_bad_width
    $error("complex_mag_stream_mul_pipe: widths exceed saturation container");
  end
  if (ID < 0) begin : g_bad_id
    $error("complex_mag_stream_mul_pipe: ID must be non-negative");
  end

  // One extra bit turns either operand into a signed value: copy the MSB
  // for signed inputs, insert a zero for unsigned ones.
  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  assign a_ext = {din0_signed & din0[din0_WIDTH-1], din0};
  assign b_ext = {din1_signed & din1[din1_WIDTH-1], din1};

  logic signed [P-1:0] prod;
  logic signed [P-1:0] shifted;
  wide_t               sh_wide;
  assign prod    = P'(a_ext) * P'(b_ext);
  assign shifted = prod >>> SHIFT;  // floor division by 2^SHIFT
  assign sh_wide = WIDE_W'(shifted);

  logic [dout_WIDTH-1:0] sat_data;
  logic                  sat_flag;
  always_comb begin
    sat_flag = 1'b0;
    sat_data = sh_wide[dout_WIDTH-1:0];
    if (sh_wide > MAX_V) begin
      sat_flag = 1'b1;
      sat_data = MAX_V[dout_WIDTH-1:0];
    end else if (sh_wide < MIN_V) begin
      sat_flag = 1'b1;
      sat_data = MIN_V[dout_WIDTH-1:0];
    end
  end

  // Stage 1: bubbles (in_valid=0) still load data; only valid marks them.
  logic [BW-1:0] stage1_q, stage1_d;
  always_comb begin
    stage1_d = stage1_q;
    if (ce) begin
      stage1_d = {in_valid, sat_flag, sat_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage1_q <= '0;
    end else begin
      stage1_q <= stage1_d;
    end
  end

  logic [BW-1:0] out_bundle;
  complex_mag_stream_pipe_reg #(
    .WIDTH (BW),
    .DEPTH (NUM_STAGE - 1)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .din   (stage1_q),
    .dout  (out_bundle)
  );

  assign {out_valid, sat, dout} = out_bundle;

endmodule
